fir_interp_polyphase: RTL and testbench
=======================================

// Module: fir_interp_polyphase
// PURPOSE
//  Polyphase interpolating FIR, upsample by INTERP_FACTOR (L), for the interpolator chain.
//  Each accepted input sample yields L outputs. Output phase p uses taps coeff[p+L*k], k=0..TAPS_PER_PHASE-1.
//  A single time-multiplexed MAC computes the outputs. Valid/ready handshake on both sides.
// PARAMETERS
//  INPUT_WORD_SIZE   16  signed input sample width
//  COEFF_WORD_SIZE   16  signed coefficient width
//  INTERP_FACTOR      4  L, outputs per input (>=2)
//  TAPS_PER_PHASE     4  T, taps per phase (>=2); N_COEFFS = L*T (localparam)
//  OUTPUT_WORD_SIZE  (localparam) INPUT_WORD_SIZE+COEFF_WORD_SIZE+$clog2(T)
// PORTS
//  clk           in   1                     clock, rising edge
//  arst_n        in   1                     async reset, active-low
//  bypass        in   1                     pass-through mode, sampled at input accept
//  coeff         in   N_COEFFS*COEFF_WS     flat signed taps, tap n at [n*COEFF_WS +: COEFF_WS]
//  data_in       in   INPUT_WORD_SIZE       signed input sample
//  valid_in      in   1                     input valid
//  ready_out     out  1                     input ready (state==IDLE)
//  data_out      out  OUTPUT_WORD_SIZE      signed output, registered
//  valid_out     out  1                     output valid (state==HOLD)
//  ready_in      in   1                     downstream ready
//  flush         in   1                     only with FIR_INTERP_FLUSH_EN, see CONFIGURATION
// BEHAVIOUR
//  Reset (async, arst_n=0):
//   - state=IDLE; delay line, acc, phase p, tap k = 0
//   - data_out=0, valid_out=0, ready_out=1
//  Delay line:
//   - T entries dl[0..T-1], dl[0] newest
//   - On accept: dl[0]<=data_in, dl[i]<=dl[i-1]
//   - Otherwise held
//  FSM:
//   - IDLE: ready_out=1.
//     - On valid_in&ready_out (accept), shift delay line and latch bp_r<=bypass.
//     - If bypass: data_out<={sign-ext data_in, (COEFF_WS-1) zeros}, go to HOLD.
//     - Else: p=0, k=0, acc=0, go to MAC.
//   - MAC: one product per cycle, acc+=dl[k]*coeff[p+L*k], k++.
//     - On k==T-1, data_out<=final sum (acc plus last product), go to HOLD.
//   - HOLD: valid_out=1, data_out stable until ready_in.
//     - On ready_in:
//       - if bp_r or p==L-1, go to IDLE;
//       - else p++, k=0, acc=0, go to MAC.
//  Latency and throughput:
//   - First output valid T cycles after the accept edge.
//   - Each later phase is valid T cycles after the previous handshake.
//   - Input throughput is at most 1 sample per L*(T+1) cycles.
//  Arithmetic:
//   - Products are full-precision signed.
//   - acc and data_out are OUTPUT_WORD_SIZE signed; no rounding or saturation.
//   - The width is sized so T worst-case products, including (-2^(IW-1))*(-2^(CW-1)), cannot overflow.
//  Boundaries and constraints:
//   - valid_in outside IDLE is ignored; no accept occurs.
//   - ready_in outside HOLD is ignored.
//   - coeff must be static while not IDLE; it is read live in MAC.
//   - bypass changes take effect only at the next accept.
//   - Reset mid-burst discards the burst; no partial output is emitted.
// CONFIGURATION
//  FIR_INTERP_FLUSH_EN defined:
//   - Adds the flush input port.
//   - flush=1 at any edge: delay line, acc, p, k cleared; state=IDLE; valid_out=0; data_out=0.
//   - The burst in progress is discarded.
//   - Flush has priority over a simultaneous accept; the sample is not taken.
//  FIR_INTERP_FLUSH_EN undefined:
//   - No flush port; the delay line is cleared only by arst_n.
// TESTING (L=4, T=4, IW=CW=16 unless noted)
//  1 Impulse, coeff[n]=n+1, inputs 1,0,0,0, ready_in=1:
//    -> outputs 1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16; then zeros.
//  2 DC, all coeff=1, data_in=100 continuously:
//    -> after 4 inputs every output =400; first 16 outputs ramp 100x4, 200x4, 300x4, 400x4.
//  3 Backpressure: ready_in=0 for 10 cycles in HOLD
//    -> valid_out=1, data_out constant, ready_out=0; phase advances only after ready_in=1.
//  4 Bypass=1, data_in=-3 -> single output data_out=-98304 (-3<<15), then IDLE; delay line holds -3.
//  5 Extremes: all coeff=-32768, four inputs -32768 -> output 2^32, no wrap in 34-bit data_out.
//  6 arst_n pulsed in MAC phase 2 -> valid_out=0, data_out=0, ready_out=1;
//    with FIR_INTERP_FLUSH_EN, flush pulse gives the same state with the delay line zero.

Source files
------------

// File: rtl/fir_interp_polyphase_if.sv
// ============================================================================
// Module : fir_interp_polyphase_if
// Brief  : Valid/ready stream bundle for the polyphase interpolator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fir_interp_polyphase_if #(
  parameter int INPUT_WORD_SIZE  = 16,
  parameter int OUTPUT_WORD_SIZE = 34
);
  logic signed [INPUT_WORD_SIZE-1:0]  data_in;
  logic                               valid_in;
  logic                               ready_out;
  logic signed [OUTPUT_WORD_SIZE-1:0] data_out;
  logic                               valid_out;
  logic                               ready_in;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
  );
endinterface

`default_nettype wire

// File: rtl/fir_interp_polyphase.sv
// ============================================================================
// Module : fir_interp_polyphase
// Brief  : Polyphase interpolating FIR (xL) with one time-multiplexed MAC.
//          Optional flush port enabled by defining FIR_INTERP_FLUSH_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_interp_polyphase #(
  parameter int INPUT_WORD_SIZE = 16,
  parameter int COEFF_WORD_SIZE = 16,
  parameter int INTERP_FACTOR   = 4,
  parameter int TAPS_PER_PHASE  = 4
) (
  input  wire logic clk,
  input  wire logic arst_n,
  input  wire logic bypass,
  input  wire logic [INTERP_FACTOR*TAPS_PER_PHASE*COEFF_WORD_SIZE-1:0] coeff,
`ifdef FIR_INTERP_FLUSH_EN
  input  wire logic flush,
`endif
  fir_interp_polyphase_if.slave bus
);

  localparam int N_COEFFS         = INTERP_FACTOR * TAPS_PER_PHASE;
  localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(TAPS_PER_PHASE);
  localparam int PROD_W           = INPUT_WORD_SIZE + COEFF_WORD_SIZE;
  localparam int P_W              = $clog2(INTERP_FACTOR);
  localparam int K_W              = $clog2(TAPS_PER_PHASE);
  localparam int IDX_W            = $clog2(N_COEFFS);
  localparam int EXT_W            = OUTPUT_WORD_SIZE - PROD_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                              r_state;
  logic signed [INPUT_WORD_SIZE-1:0]   r_dl [TAPS_PER_PHASE];
  logic signed [OUTPUT_WORD_SIZE-1:0]  r_acc;
  logic signed [OUTPUT_WORD_SIZE-1:0]  r_data_out;
  logic [P_W-1:0]                      r_p;
  logic [K_W-1:0]                      r_k;
  logic                                r_bp;
  logic                                r_valid;
  logic                                r_ready;

  logic                                w_flush;
  logic                                w_accept;
  logic                                w_last_k;
  logic                                w_last_p;
  logic [IDX_W-1:0]                    w_idx;
  logic signed [COEFF_WORD_SIZE-1:0]   w_coeff;
  logic signed [INPUT_WORD_SIZE-1:0]   w_tap;
  logic signed [PROD_W-1:0]            w_prod;
  logic signed [OUTPUT_WORD_SIZE-1:0]  w_sum;
  logic signed [OUTPUT_WORD_SIZE-1:0]  w_bypass_val;

`ifdef FIR_INTERP_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // ready_out is registered and high exactly when the FSM sits in IDLE
  assign w_accept = bus.valid_in && r_ready;
  assign w_last_k = (r_k == K_W'(TAPS_PER_PHASE - 1));
  assign w_last_p = (r_p == P_W'(INTERP_FACTOR - 1));

  // Phase p, tap k reads coefficient p + L*k; coeff is sampled live each MAC cycle
  assign w_idx   = IDX_W'(r_p) + IDX_W'(INTERP_FACTOR * int'(r_k));
  assign w_coeff = $signed(coeff[w_idx*COEFF_WORD_SIZE +: COEFF_WORD_SIZE]);
  assign w_tap   = r_dl[r_k];
  assign w_prod  = w_tap * w_coeff;
  assign w_sum   = r_acc + {{EXT_W{w_prod[PROD_W-1]}}, w_prod};

  assign w_bypass_val = {{(EXT_W + 1){bus.data_in[INPUT_WORD_SIZE-1]}},
                         bus.data_in, {(COEFF_WORD_SIZE - 1){1'b0}}};

  assign bus.ready_out = r_ready;
  assign bus.valid_out = r_valid;
  assign bus.data_out  = r_data_out;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < TAPS_PER_PHASE; i++) r_dl[i] <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < TAPS_PER_PHASE; i++) r_dl[i] <= '0;
    end else if (w_accept) begin
      r_dl[0] <= bus.data_in;
      for (int i = 1; i < TAPS_PER_PHASE; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_data_out <= '0;
      r_p        <= '0;
      r_k        <= '0;
      r_bp       <= 1'b0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b1;
    end else if (w_flush) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_data_out <= '0;
      r_p        <= '0;
      r_k        <= '0;
      r_bp       <= 1'b0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bp    <= bypass;
            r_ready <= 1'b0;
            if (bypass) begin
              r_data_out <= w_bypass_val;
              r_valid    <= 1'b1;
              r_state    <= S_HOLD;
            end else begin
              r_p     <= '0;
              r_k     <= '0;
              r_acc   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (w_last_k) begin
            r_k        <= '0;
            r_data_out <= w_sum;
            r_valid    <= 1'b1;
            r_state    <= S_HOLD;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.ready_in) begin
            r_valid <= 1'b0;
            if (r_bp || w_last_p) begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_p     <= r_p + 1'b1;
              r_k     <= '0;
              r_acc   <= '0;
              r_state <= S_MAC;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_interp_polyphase.sv
// ============================================================================
// Module : tb_fir_interp_polyphase
// Brief  : Directed vector bench for fir_interp_polyphase (L=4, T=4, 16x16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_interp_polyphase;

  localparam int IW = 16;
  localparam int CW = 16;
  localparam int L  = 4;
  localparam int T  = 4;
  localparam int OW = IW + CW + $clog2(T);

  logic                clk;
  logic                arst_n;
  logic                bypass;
  logic [L*T*CW-1:0]   coeff;
`ifdef FIR_INTERP_FLUSH_EN
  logic                flush;
`endif

  fir_interp_polyphase_if #(.INPUT_WORD_SIZE(IW), .OUTPUT_WORD_SIZE(OW)) bus ();

  fir_interp_polyphase #(
    .INPUT_WORD_SIZE(IW),
    .COEFF_WORD_SIZE(CW),
    .INTERP_FACTOR  (L),
    .TAPS_PER_PHASE (T)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bypass (bypass),
    .coeff  (coeff),
`ifdef FIR_INTERP_FLUSH_EN
    .flush  (flush),
`endif
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit           rst;
    int           cmode;
    logic signed [IW-1:0] din;
    bit           bp;
    int           nexp;
    longint       e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit rst, input int cm, input int din, input bit bp, input int n,
                     input longint e0, input longint e1, input longint e2, input longint e3);
    vec_t v;
    v.rst = rst; v.cmode = cm; v.din = IW'(din); v.bp = bp; v.nexp = n;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    vecs.push_back(v);
  endtask

  // mode 0: coeff[n]=n+1, mode 1: all ones, mode 2: all most-negative
  task automatic set_coeff(input int mode);
    for (int n = 0; n < L*T; n++) begin
      case (mode)
        0:       coeff[n*CW +: CW] = CW'(n + 1);
        1:       coeff[n*CW +: CW] = CW'(1);
        default: coeff[n*CW +: CW] = 16'h8000;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n       = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    bypass       = 1'b0;
    @(negedge clk);
    chk("reset ready_out", bus.ready_out, 1);
    chk("reset valid_out", bus.valid_out, 0);
    chk("reset data_out", $signed(bus.data_out), 0);
    arst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic send_sample(input logic signed [IW-1:0] d, input logic bp);
    int c;
    c = 0;
    @(negedge clk);
    while (!bus.ready_out && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (c >= 100) chk("accept ready wait", bus.ready_out, 1);
    bus.data_in  = d;
    bypass       = bp;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bypass       = 1'b0;
  endtask

  task automatic get_output(input string nm, input longint exp, input int lat);
    int c;
    c = 0;
    @(negedge clk);
    while (!bus.valid_out && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " latency"}, c, lat);
    chk({nm, " data"}, $signed(bus.data_out), exp);
    @(posedge clk);
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, " idle ready_out"}, bus.ready_out, 1);
    chk({nm, " idle valid_out"}, bus.valid_out, 0);
  endtask

  initial begin
    longint ex[4];
    int     quiet;

    arst_n       = 1'b0;
    bypass       = 1'b0;
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
`ifdef FIR_INTERP_FLUSH_EN
    flush        = 1'b0;
`endif
    set_coeff(0);

    // impulse through coeff n+1, then DC ramp, bypass, delay-line carry-over, extremes
    add(1, 0, 1, 0, 4, 1, 2, 3, 4);
    add(0, 0, 0, 0, 4, 5, 6, 7, 8);
    add(0, 0, 0, 0, 4, 9, 10, 11, 12);
    add(0, 0, 0, 0, 4, 13, 14, 15, 16);
    add(0, 0, 0, 0, 4, 0, 0, 0, 0);
    add(0, 1, 100, 0, 4, 100, 100, 100, 100);
    add(0, 1, 100, 0, 4, 200, 200, 200, 200);
    add(0, 1, 100, 0, 4, 300, 300, 300, 300);
    add(0, 1, 100, 0, 4, 400, 400, 400, 400);
    add(0, 1, 100, 0, 4, 400, 400, 400, 400);
    add(0, 1, -3, 1, 1, -98304, 0, 0, 0);
    add(0, 0, 0, 0, 4, 2185, 2382, 2579, 2776);
    add(1, 2, -32768, 0, 4, 64'd1073741824, 64'd1073741824, 64'd1073741824, 64'd1073741824);
    add(0, 2, -32768, 0, 4, 64'd2147483648, 64'd2147483648, 64'd2147483648, 64'd2147483648);
    add(0, 2, -32768, 0, 4, 64'd3221225472, 64'd3221225472, 64'd3221225472, 64'd3221225472);
    add(0, 2, -32768, 0, 4, 64'd4294967296, 64'd4294967296, 64'd4294967296, 64'd4294967296);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      set_coeff(vecs[i].cmode);
      ex = '{vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3};
      send_sample(vecs[i].din, vecs[i].bp);
      for (int j = 0; j < vecs[i].nexp; j++)
        get_output($sformatf("vec%0d out%0d", i, j), ex[j], vecs[i].bp ? 0 : T);
      check_idle($sformatf("vec%0d", i));
    end

    // backpressure: hold phase 0 for 10 cycles while a stray valid_in is offered
    do_reset();
    set_coeff(0);
    bus.ready_in = 1'b0;
    send_sample(16'sd1, 1'b0);
    begin
      int c;
      c = 0;
      @(negedge clk);
      while (!bus.valid_out && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("bp first latency", c, T);
    end
    for (int i = 0; i < 10; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = 16'sd77;
      @(negedge clk);
      chk($sformatf("bp hold%0d valid_out", i), bus.valid_out, 1);
      chk($sformatf("bp hold%0d data_out", i), $signed(bus.data_out), 1);
      chk($sformatf("bp hold%0d ready_out", i), bus.ready_out, 0);
    end
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    @(posedge clk);
    get_output("bp out1", 2, T);
    get_output("bp out2", 3, T);
    get_output("bp out3", 4, T);
    check_idle("bp");
    send_sample(16'sd0, 1'b0);
    for (int j = 0; j < L; j++) get_output($sformatf("bp next out%0d", j), 5 + j, T);
    check_idle("bp next");

    // asynchronous reset in the middle of phase 2
    do_reset();
    set_coeff(0);
    send_sample(16'sd1, 1'b0);
    get_output("rst out0", 1, T);
    get_output("rst out1", 2, T);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("midrst valid_out", bus.valid_out, 0);
    chk("midrst data_out", $signed(bus.data_out), 0);
    chk("midrst ready_out", bus.ready_out, 1);
    @(negedge clk);
    arst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.valid_out) quiet = 0;
    end
    chk("midrst no stray output", quiet, 1);
    send_sample(16'sd0, 1'b0);
    for (int j = 0; j < L; j++) get_output($sformatf("midrst dl out%0d", j), 0, T);
    check_idle("midrst");

`ifdef FIR_INTERP_FLUSH_EN
    // flush mid-burst, then flush against a simultaneous accept
    set_coeff(0);
    send_sample(16'sd1, 1'b0);
    get_output("flush out0", 1, T);
    get_output("flush out1", 2, T);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush valid_out", bus.valid_out, 0);
    chk("flush data_out", $signed(bus.data_out), 0);
    chk("flush ready_out", bus.ready_out, 1);
    @(negedge clk);
    flush        = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in  = 16'sd5;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.valid_in = 1'b0;
    chk("flush vs accept ready_out", bus.ready_out, 1);
    send_sample(16'sd0, 1'b0);
    for (int j = 0; j < L; j++) get_output($sformatf("flush dl out%0d", j), 0, T);
    check_idle("flush");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
